traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
- Phase sequencer for a two-road intersection (NS / EW).
- Sits directly downstream of the second counter. It consumes that counter's one-cycle `last` pulse as `sec_tick`, i.e. one pulse per elapsed second.
- Drives the lamp outputs and a 7-bit remaining-seconds value for the countdown display.
- Honours a pedestrian request by shortening the active green.

Parameters:
- GREEN_SEC, 30, green duration in seconds (1..99)
- YELLOW_SEC, 3, yellow duration in seconds (1..99)
- CLR_SEC, 2, all-red clearance duration in seconds (1..99)
- PED_MIN_SEC, 5, green remaining after a pedestrian request (1..GREEN_SEC)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sec_tick  in  1  one-cycle pulse per second, from the second counter's `last`
- ped_req  in  1  pedestrian request, level or pulse, sampled every clk
- ns_light  out  3  {red,yellow,green}, one-hot
- ew_light  out  3  {red,yellow,green}, one-hot
- remain  out  7  seconds left in the current phase (1..99)
- phase  out  3  current state encoding
- ped_pending  out  1  request latched and not yet served

Behaviour:
- All outputs are registered. Outputs change only on a clk edge, or asynchronously on rst.
- States, entered in this cyclic order:
  - ALLRED_A (CLR_SEC)
  - NS_GREEN (GREEN_SEC)
  - NS_YELLOW (YELLOW_SEC)
  - ALLRED_B (CLR_SEC)
  - EW_GREEN (GREEN_SEC)
  - EW_YELLOW (YELLOW_SEC)
  - back to ALLRED_A
- Reset values: phase=ALLRED_A, remain=CLR_SEC, ns_light=ew_light=3'b100, ped_pending=0.
- Lamp encoding per state:
  - ALLRED: both lamps red.
  - NS_GREEN / NS_YELLOW: ns_light is green / yellow; ew_light is red.
  - EW states: mirror image of the NS states.
- Timing rule, evaluated on each cycle with sec_tick=1:
  - remain==1: advance to the next state and load that state's duration.
  - otherwise: remain decrements by 1.
- sec_tick=0: state and remain hold.
- Each state therefore lasts exactly its duration in ticks. remain never shows 0.
- Pedestrian request:
  - ped_req=1 in any cycle sets ped_pending.
  - In a GREEN state, if the next remain value (after any same-cycle decrement) exceeds PED_MIN_SEC, it is clamped to PED_MIN_SEC.
  - Clamping never lengthens a phase. A request with remain ≤ PED_MIN_SEC has no timing effect.
  - ped_pending clears on entry to NS_YELLOW or EW_YELLOW.
  - A ped_req in the same cycle as that entry keeps ped_pending set (set wins).
  - A request raised outside green is carried to the next green, which starts at min(GREEN_SEC, PED_MIN_SEC) on entry.
- Simultaneous sec_tick and remain==1 with ped_req: the transition wins. The clamp applies only to green-state remain.
- rst mid-phase: immediate return to the reset values. Partial counts are discarded.
- Undefined phase encodings recover to ALLRED_A with remain=CLR_SEC on the next clk.
- Width: remain is 7 bits, unsigned. Parameters above 99 are illegal; the RTL checks this with a simulation-only assertion.

Optional Feature:
- Macro: TLC_NIGHT_FLASH_EN.
- With the macro defined:
  - Adds input port night_mode (1 bit) and a state FLASH.
  - night_mode=1 is sampled on a sec_tick; from any state this enters FLASH on that tick.
  - In FLASH, both lamps show yellow, toggling on/off (3'b010 / 3'b000) on every sec_tick, starting with on. remain holds at 0.
  - night_mode=0 on a sec_tick while in FLASH goes to ALLRED_A with remain=CLR_SEC.
  - ped_req is ignored in FLASH, and ped_pending is cleared there.
- Without the macro: no night_mode port, no FLASH encoding, and remain is never 0.

Decomposition:
- Shared header tlc_defs.vh holds:
  - the state encodings (3-bit), including FLASH;
  - the lamp constants RED=3'b100, YEL=3'b010, GRN=3'b001, OFF=3'b000.
- One sub-module, tlc_phase_timer, handles the countdown.
  - Inputs: load, load_val, tick, clamp_en, clamp_val.
  - Outputs: remain, expire (remain==1 && tick).
- The top-level FSM selects the duration to load and decodes the lamps.

Test Plan:
- Reset, then 2 ticks → ALLRED_A; remain goes 2→1, then NS_GREEN with remain=30, ns=001, ew=100.
- Full cycle of 2+30+3+2+30+3=70 ticks → back to ALLRED_A; each lamp is one-hot and never green on both roads.
- ped_req pulse at NS_GREEN remain=20 → next cycle remain=5 and ped_pending=1; 5 ticks later NS_YELLOW with ped_pending=0.
- ped_req at NS_GREEN remain=4 → remain still counts 4,3,2,1 with no clamp; ped_req during EW_YELLOW → next NS_GREEN enters with remain=5.
- rst asserted at EW_GREEN remain=12 without a clk edge → outputs return to reset values immediately; sec_tick held low for 50 cycles → no state change.
- TLC_NIGHT_FLASH_EN defined: night_mode=1 at NS_GREEN, then 4 ticks → FLASH, lamps 010,000,010,000; night_mode=0 at the next tick → ALLRED_A with remain=2.

Source files
------------

// File: rtl/traffic_light_ctrl_pkg.sv
// traffic_light_ctrl_pkg: state encodings, lamp constants and sequencing helpers
// (FLASH is only reachable when TLC_NIGHT_FLASH_EN is defined).
package traffic_light_ctrl_pkg;
  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    FLASH     = 3'd6
  } state_e;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  function automatic state_e next_state(input state_e s);
    case (s)
      ALLRED_A:  return NS_GREEN;
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALLRED_B;
      ALLRED_B:  return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      default:   return ALLRED_A;
    endcase
  endfunction
  function automatic logic [2:0] ns_lamp(input state_e s);
    return s == NS_GREEN ? GRN : s == NS_YELLOW ? YEL : RED;
  endfunction
  function automatic logic [2:0] ew_lamp(input state_e s);
    return s == EW_GREEN ? GRN : s == EW_YELLOW ? YEL : RED;
  endfunction
endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: per-phase seconds countdown with load and optional downward clamp.
module tlc_phase_timer #(
  parameter logic [6:0] RST_VAL = 7'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       tick,
  input  logic       clamp_en,
  input  logic [6:0] clamp_val,
  output logic [6:0] remain,
  output logic       expire
);
  logic [6:0] remain_q, remain_d, step;
  // The clamp only ever shortens the value after this cycle's decrement; a load overrides it.
  always_comb begin
    step = tick ? remain_q - 7'd1 : remain_q;
    remain_d = load ? load_val : (clamp_en && step > clamp_val) ? clamp_val : step;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) remain_q <= RST_VAL;
    else remain_q <= remain_d;
  assign remain = remain_q;
  assign expire = tick && remain_q == 7'd1;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road phase sequencer with pedestrian green shortening;
// TLC_NIGHT_FLASH_EN adds a night_mode input and a flashing-yellow FLASH state.
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int GREEN_SEC   = 30,
  parameter int YELLOW_SEC  = 3,
  parameter int CLR_SEC     = 2,
  parameter int PED_MIN_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       ped_req,
`ifdef TLC_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [6:0] remain,
  output logic [2:0] phase,
  output logic       ped_pending
);
  localparam logic [6:0] GREEN7 = 7'(GREEN_SEC);
  localparam logic [6:0] YEL7   = 7'(YELLOW_SEC);
  localparam logic [6:0] CLR7   = 7'(CLR_SEC);
  localparam logic [6:0] PED7   = 7'(PED_MIN_SEC);
  state_e     state_q, state_d, nxt;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic       ped_q, ped_d, ped_any, green_q, valid, load, expire;
  logic [6:0] load_val;
  assign ped_any = ped_req | ped_q;
  assign green_q = state_q == NS_GREEN || state_q == EW_GREEN;
`ifdef TLC_NIGHT_FLASH_EN
  assign valid = state_q <= FLASH;
`else
  assign valid = state_q <= EW_YELLOW;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ALLRED_A;
      ns_q    <= RED;
      ew_q    <= RED;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      ped_q   <= ped_d;
    end
  always_comb begin
    nxt = next_state(state_q);
    state_d = state_q;
    load = 1'b0;
    load_val = CLR7;
    if (!valid) begin
      state_d = ALLRED_A;
      load = 1'b1;
    end
`ifdef TLC_NIGHT_FLASH_EN
    else if (sec_tick && night_mode) begin
      state_d = FLASH;
      load = 1'b1;
      load_val = 7'd0;
    end else if (state_q == FLASH) begin
      state_d = sec_tick ? ALLRED_A : FLASH;
      load = sec_tick;
    end
`endif
    else if (expire) begin
      state_d = nxt;
      load = 1'b1;
      load_val = (nxt == NS_GREEN || nxt == EW_GREEN) ? (ped_any ? PED7 : GREEN7)
               : (nxt == NS_YELLOW || nxt == EW_YELLOW) ? YEL7 : CLR7;
    end
  end
  // A request in the same cycle as yellow entry survives the clear.
  always_comb begin
    ns_d = ns_lamp(state_d);
    ew_d = ew_lamp(state_d);
    ped_d = ped_req | (ped_q & ~((state_d == NS_YELLOW || state_d == EW_YELLOW) && state_d != state_q));
`ifdef TLC_NIGHT_FLASH_EN
    if (state_d == FLASH) begin
      ns_d = state_q != FLASH ? YEL : sec_tick ? (ns_q == OFF ? YEL : OFF) : ns_q;
      ew_d = ns_d;
      ped_d = 1'b0;
    end
`endif
  end
  tlc_phase_timer #(.RST_VAL(CLR7)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .tick      (sec_tick),
    .clamp_en  (green_q & ped_any),
    .clamp_val (PED7),
    .remain    (remain),
    .expire    (expire)
  );
  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign phase       = state_q;
  assign ped_pending = ped_q;
  param_range_a: assert property (@(posedge clk)
    GREEN_SEC >= 1 && GREEN_SEC <= 99 && YELLOW_SEC >= 1 && YELLOW_SEC <= 99 &&
    CLR_SEC >= 1 && CLR_SEC <= 99 && PED_MIN_SEC >= 1 && PED_MIN_SEC <= GREEN_SEC);
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed-vector bench for traffic_light_ctrl (night flash steps need TLC_NIGHT_FLASH_EN).
module tb_traffic_light_ctrl;
  import traffic_light_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1, sec_tick = 1'b0, ped_req = 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
  logic night_mode = 1'b0;
`endif
  logic [2:0] ns_light, ew_light, phase;
  logic [6:0] remain;
  logic       ped_pending;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  traffic_light_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .sec_tick    (sec_tick),
    .ped_req     (ped_req),
`ifdef TLC_NIGHT_FLASH_EN
    .night_mode  (night_mode),
`endif
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .remain      (remain),
    .phase       (phase),
    .ped_pending (ped_pending)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic st(input string tag, input logic [2:0] ph, input logic [6:0] rem,
                    input logic [2:0] ns, input logic [2:0] ew, input logic pp);
    chk({tag, ".phase"}, {5'd0, phase}, {5'd0, ph});
    chk({tag, ".remain"}, {1'b0, remain}, {1'b0, rem});
    chk({tag, ".ns"}, {5'd0, ns_light}, {5'd0, ns});
    chk({tag, ".ew"}, {5'd0, ew_light}, {5'd0, ew});
    chk({tag, ".ped"}, {7'd0, ped_pending}, {7'd0, pp});
  endtask
  task automatic tick(input logic ped);
    @(negedge clk); sec_tick = 1'b1; ped_req = ped;
    @(negedge clk); sec_tick = 1'b0; ped_req = 1'b0;
  endtask
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0);
      chk("lamp_safe", {7'd0, $onehot(ns_light) && $onehot(ew_light) && !(ns_light == 3'b001 && ew_light == 3'b001)}, 8'd1);
    end
  endtask
  task automatic ped_pulse();
    @(negedge clk); ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    st("reset", 3'd0, 7'd2, 3'b100, 3'b100, 1'b0);
    rst = 1'b0;
    tick_n(1);
    st("allred_a_1", 3'd0, 7'd1, 3'b100, 3'b100, 1'b0);
    tick_n(1);
    st("ns_green", 3'd1, 7'd30, 3'b001, 3'b100, 1'b0);
    tick_n(30);
    st("ns_yellow", 3'd2, 7'd3, 3'b010, 3'b100, 1'b0);
    tick_n(3);
    st("allred_b", 3'd3, 7'd2, 3'b100, 3'b100, 1'b0);
    tick_n(2);
    st("ew_green", 3'd4, 7'd30, 3'b100, 3'b001, 1'b0);
    tick_n(30);
    st("ew_yellow", 3'd5, 7'd3, 3'b100, 3'b010, 1'b0);
    tick_n(3);
    st("wrap", 3'd0, 7'd2, 3'b100, 3'b100, 1'b0);
    tick_n(12);
    st("ns_green_20", 3'd1, 7'd20, 3'b001, 3'b100, 1'b0);
    ped_pulse();
    st("ped_clamp", 3'd1, 7'd5, 3'b001, 3'b100, 1'b1);
    tick_n(4);
    st("ped_clamp_1", 3'd1, 7'd1, 3'b001, 3'b100, 1'b1);
    tick_n(1);
    st("ped_served", 3'd2, 7'd3, 3'b010, 3'b100, 1'b0);
    tick_n(31);
    st("ew_green_4", 3'd4, 7'd4, 3'b100, 3'b001, 1'b0);
    ped_pulse();
    st("ped_noclamp", 3'd4, 7'd4, 3'b100, 3'b001, 1'b1);
    tick_n(1);
    st("ped_noclamp_3", 3'd4, 7'd3, 3'b100, 3'b001, 1'b1);
    tick_n(3);
    st("ew_yellow_clr", 3'd5, 7'd3, 3'b100, 3'b010, 1'b0);
    ped_pulse();
    st("ped_in_yellow", 3'd5, 7'd3, 3'b100, 3'b010, 1'b1);
    tick_n(5);
    st("carried_green", 3'd1, 7'd5, 3'b001, 3'b100, 1'b1);
    tick_n(4);
    tick(1'b1);
    st("transition_wins", 3'd2, 7'd3, 3'b010, 3'b100, 1'b1);
    tick_n(5);
    st("ew_green_short", 3'd4, 7'd5, 3'b100, 3'b001, 1'b1);
    tick_n(5);
    st("ew_yellow_clr2", 3'd5, 7'd3, 3'b100, 3'b010, 1'b0);
    tick_n(5);
    st("ns_green_full", 3'd1, 7'd30, 3'b001, 3'b100, 1'b0);
    tick(1'b1);
    st("tick_ped_clamp", 3'd1, 7'd5, 3'b001, 3'b100, 1'b1);
    tick_n(5);
    st("ns_yellow_clr", 3'd2, 7'd3, 3'b010, 3'b100, 1'b0);
    tick_n(23);
    st("ew_green_12", 3'd4, 7'd12, 3'b100, 3'b001, 1'b0);
    #2 rst = 1'b1;
    #1 st("async_rst", 3'd0, 7'd2, 3'b100, 3'b100, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    st("no_tick_hold", 3'd0, 7'd2, 3'b100, 3'b100, 1'b0);
`ifdef TLC_NIGHT_FLASH_EN
    tick_n(2);
    night_mode = 1'b1;
    tick(1'b0);
    st("flash_on", 3'd6, 7'd0, 3'b010, 3'b010, 1'b0);
    tick(1'b0);
    st("flash_off", 3'd6, 7'd0, 3'b000, 3'b000, 1'b0);
    tick(1'b1);
    st("flash_on2", 3'd6, 7'd0, 3'b010, 3'b010, 1'b0);
    tick(1'b0);
    st("flash_off2", 3'd6, 7'd0, 3'b000, 3'b000, 1'b0);
    night_mode = 1'b0;
    tick(1'b0);
    st("flash_exit", 3'd0, 7'd2, 3'b100, 3'b100, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
